gray_counter: RTL and testbench



---
 rtl/gray_counter_if.sv | 26 ++
 rtl/gray_counter.sv | 117 +++++++++++
 tb/tb_gray_counter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_if.sv
// gray_counter_if: control and status bundle for gray_counter.
// The master drives the count controls and load value; the slave (the
// counter) returns the registered binary/Gray count, terminal count and
// the sticky Gray-step error flag.
interface gray_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] ld_gray;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc;
    logic             err;

    modport master (
        output en, up_dn, load, ld_gray,
        input  bin_q, gray_q, tc, err
    );

    modport slave (
        input  en, up_dn, load, ld_gray,
        output bin_q, gray_q, tc, err
    );
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down counter holding a binary count and its reflected
// Gray code in lock-step registers. Supports a Gray-coded synchronous load,
// wrap or saturate at the bounds and a registered terminal-count pulse.
// Optional macro GRAY_CHECK_EN adds a sticky single-bit-step checker on
// gray_q; without it err is tied low and no checker logic exists.
module gray_counter #(
    parameter int          WIDTH   = 4,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_ld_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_tc_next;
    logic             w_at_bound;

    // Convert the Gray load value to binary: each bit is the XOR of all
    // Gray bits at or above it, accumulated from the MSB downwards.
    always_comb begin
        logic acc;
        w_ld_bin = '0;
        acc      = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ bus.ld_gray[i];
            w_ld_bin[i] = acc;
        end
    end

    // The count is at the bound it is heading towards this cycle.
    assign w_at_bound = bus.up_dn ? (r_bin == MAX_VAL) : (r_bin == '0);

    // Next binary count and terminal count; load beats enable beats hold.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        w_bin_next = r_bin;
        w_tc_next  = 1'b0;
        if (bus.load) begin
            w_bin_next = w_ld_bin;
        end else if (bus.en) begin
            if (w_at_bound) begin
                w_tc_next = 1'b1;
                if (WRAP) begin
                    w_bin_next = bus.up_dn ? '0 : MAX_VAL;
                end
            end else begin
                w_bin_next = bus.up_dn ? (r_bin + 1'b1) : (r_bin - 1'b1);
            end
        end
    end

    // The Gray value always follows the binary value it is stored beside.
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Count registers; binary and Gray update together on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_bin  <= RST_BIN;
            r_gray <= RST_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_tc   <= w_tc_next;
        end
    end

    assign bus.bin_q  = r_bin;
    assign bus.gray_q = r_gray;
    assign bus.tc     = r_tc;

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] r_gray_prev;
    logic             r_step_q;
    logic             r_err;
    logic             w_step;
    logic             w_bad;

    // A real count step: enabled, not loading, and not pinned at a bound.
    assign w_step = !bus.load && bus.en && (WRAP || !w_at_bound);

    // After a real step exactly one Gray bit may have changed.
    assign w_bad = r_step_q && ($countones(r_gray ^ r_gray_prev) != 1);

    // Previous Gray value, step marker and sticky error; the marker resets
    // low so the first edge after reset release is never checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray_prev <= RST_GRAY;
            r_step_q    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_gray_prev <= r_gray;
            r_step_q    <= w_step;
            r_err       <= r_err | w_bad;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: scoreboard bench for gray_counter. Three instances run
// side by side (4-bit wrap, 4-bit saturate, 6-bit wrap with a non-zero
// reset value). Each stimulus cycle pushes reference-model results into
// per-instance queues; a negedge monitor pops and compares them.
module tb_gray_counter;
    localparam int RST_C = 37;

    typedef struct {
        int due;
        int bin;
        int gray;
        bit tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    gray_counter_if #(.WIDTH(4)) if_a ();
    gray_counter_if #(.WIDTH(4)) if_b ();
    gray_counter_if #(.WIDTH(6)) if_c ();

    gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );
    gray_counter #(.WIDTH(6), .WRAP(1'b1), .RST_VAL(RST_C)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;
    bit   track    = 1'b1;
    int   m_a, m_b, m_c;
    exp_t q_a[$], q_b[$], q_c[$];
    exp_t e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by search: the unique value whose Gray code matches.
    function automatic int from_gray(input int g, input int w);
        for (int b = 0; b < (1 << w); b++)
            if (to_gray(b) == g) return b;
        return -1;
    endfunction

    // Reference step: plain integer arithmetic, out-of-range is a bound hit.
    task automatic model(input int w, input bit wrap, input bit en, input bit up,
                         input bit ld, input int g, inout int bin, output bit tc);
        int span;
        int nb;
        span = 1 << w;
        tc   = 1'b0;
        if (ld) begin
            bin = from_gray(g, w);
        end else if (en) begin
            nb = up ? bin + 1 : bin - 1;
            if (nb < 0 || nb >= span) begin
                tc = 1'b1;
                nb = wrap ? ((nb % span) + span) % span : bin;
            end
            bin = nb;
        end
    endtask

    task automatic set_inputs(input bit en, input bit up, input bit ld, input int g4, input int g6);
        if_a.en = en; if_a.up_dn = up; if_a.load = ld; if_a.ld_gray = 4'(g4);
        if_b.en = en; if_b.up_dn = up; if_b.load = ld; if_b.ld_gray = 4'(g4);
        if_c.en = en; if_c.up_dn = up; if_c.load = ld; if_c.ld_gray = 6'(g6);
    endtask

    // One stimulus cycle: apply inputs, queue the model's result, take an edge.
    task automatic drive(input bit en, input bit up, input bit ld, input int g4, input int g6);
        bit ta, tb, tcc;
        set_inputs(en, up, ld, g4, g6);
        if (track) begin
            model(4, 1'b1, en, up, ld, g4, m_a, ta);
            model(4, 1'b0, en, up, ld, g4, m_b, tb);
            model(6, 1'b1, en, up, ld, g6, m_c, tcc);
            q_a.push_back('{edge_cnt + 1, m_a, to_gray(m_a), ta});
            q_b.push_back('{edge_cnt + 1, m_b, to_gray(m_b), tb});
            q_c.push_back('{edge_cnt + 1, m_c, to_gray(m_c), tcc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input exp_t x, input logic [63:0] bin,
                       input logic [63:0] gray, input logic [63:0] tc, input logic [63:0] err);
        check({tag, "_bin"},  bin,  64'(x.bin));
        check({tag, "_gray"}, gray, 64'(x.gray));
        check({tag, "_tc"},   tc,   64'(x.tc));
        check({tag, "_err"},  err,  64'd0);
    endtask

    // Monitor: compare every queued result whose edge has happened.
    always @(negedge clk) begin
        while (q_a.size() > 0 && q_a[0].due <= edge_cnt) begin
            e = q_a.pop_front();
            cmp("a", e, 64'(if_a.bin_q), 64'(if_a.gray_q), 64'(if_a.tc), 64'(if_a.err));
        end
        while (q_b.size() > 0 && q_b[0].due <= edge_cnt) begin
            e = q_b.pop_front();
            cmp("b", e, 64'(if_b.bin_q), 64'(if_b.gray_q), 64'(if_b.tc), 64'(if_b.err));
        end
        while (q_c.size() > 0 && q_c[0].due <= edge_cnt) begin
            e = q_c.pop_front();
            cmp("c", e, 64'(if_c.bin_q), 64'(if_c.gray_q), 64'(if_c.tc), 64'(if_c.err));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_a_bin"},  64'(if_a.bin_q),  64'd0);
        check({tag, "_a_gray"}, 64'(if_a.gray_q), 64'd0);
        check({tag, "_a_tc"},   64'(if_a.tc),     64'd0);
        check({tag, "_a_err"},  64'(if_a.err),    64'd0);
        check({tag, "_b_bin"},  64'(if_b.bin_q),  64'd0);
        check({tag, "_c_bin"},  64'(if_c.bin_q),  64'(RST_C));
        check({tag, "_c_gray"}, 64'(if_c.gray_q), 64'(to_gray(RST_C)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 0, 0);
        m_a = 0; m_b = 0; m_c = RST_C;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // Up through the full range and wrap, then down across zero.
        repeat (16) drive(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (2)  drive(1'b1, 1'b0, 1'b0, 0, 0);

        // Load has priority over enable; then resume counting up.
        drive(1'b1, 1'b1, 1'b1, 4'b1101, 6'b101101);
        drive(1'b1, 1'b1, 1'b0, 0, 0);

        // Load the top value, press against it, then step back down.
        drive(1'b0, 1'b0, 1'b1, 4'b1000, 6'b100000);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);

        // Direction reversal: up at 5 then down gives 6 then 5.
        drive(1'b0, 1'b0, 1'b1, to_gray(5), to_gray(5));
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);

        // Asynchronous reset between edges at count 7.
        drive(1'b0, 1'b0, 1'b1, 4'b0100, to_gray(7));
        set_inputs(1'b1, 1'b1, 1'b0, 0, 0);
        @(negedge clk);
        #2;
        check("pre_rst_a_bin", 64'(if_a.bin_q), 64'd7);
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        @(posedge clk);
        #1;
        check_reset_state("held");
        rst_n = 1'b1;
        #1;
        check_reset_state("released");
        m_a = 0; m_b = 0; m_c = RST_C;
        drive(1'b1, 1'b1, 1'b0, 0, 0);

        // Random mix of enable, direction and loads.
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 63));
        end
        set_inputs(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("queues_drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

`ifdef GRAY_CHECK_EN
        // Corrupt the binary register mid-count: the Gray jump must latch err.
        track = 1'b0;
        drive(1'b0, 1'b0, 1'b1, to_gray(3), 0);
        set_inputs(1'b1, 1'b1, 1'b0, 0, 0);
        @(negedge clk);
        force dut_a.r_bin = 4'd12;
        @(posedge clk);
        #1;
        release dut_a.r_bin;
        repeat (2) @(posedge clk);
        #1;
        check("err_set", 64'(if_a.err), 64'd1);
        set_inputs(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 64'(if_a.err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 64'(if_a.err), 64'd0);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
